// File: rtl/reg_file_wb.sv
// Purpose : RV32I architectural register file and write-back stage. x0 is hardwired to zero, and a debug counter tracks retired writes.
// Latency : a write commits on the edge it is presented. Read data is registered and appears one cycle after rd_op. A same-edge write is bypassed to the read.
// Backpressure: none. A read can be issued every cycle, and the write port accepts one write per cycle.
// Ports   : clk/rst (synchronous, active-high)
//           reg_w_op/reg_w_reg_idx/reg_w_reg_val: write request
//           rd_op/reg_rs1/reg_rs2: read request
//           reg_rs1_val/reg_rs2_val/rd_valid: registered read response
//           wb_count/wb_last_idx: debug count of committed writes and index of the last one
module reg_file_wb #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_w_op,
    input  logic [REG_IDX_W-1:0] reg_w_reg_idx,
    input  logic [XLEN-1:0]      reg_w_reg_val,
    input  logic                 rd_op,
    input  logic [REG_IDX_W-1:0] reg_rs1,
    input  logic [REG_IDX_W-1:0] reg_rs2,
    output logic [XLEN-1:0]      reg_rs1_val,
    output logic [XLEN-1:0]      reg_rs2_val,
    output logic                 rd_valid,
    output logic [CNT_W-1:0]     wb_count,
    output logic [REG_IDX_W-1:0] wb_last_idx
);

    localparam int NREG = 1 << REG_IDX_W;

    logic [XLEN-1:0]      regs_q [NREG];
    logic [XLEN-1:0]      rs1_val_q, rs1_val_d;
    logic [XLEN-1:0]      rs2_val_q, rs2_val_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]     wb_count_q, wb_count_d;
    logic [REG_IDX_W-1:0] wb_last_idx_q, wb_last_idx_d;
    logic                 commit;

    // A write to x0 is dropped entirely. It is neither stored nor counted.
    assign commit = reg_w_op && (reg_w_reg_idx != '0);

    always_comb begin
        rs1_val_d     = rs1_val_q;
        rs2_val_d     = rs2_val_q;
        rd_valid_d    = rd_op;
        wb_count_d    = wb_count_q;
        wb_last_idx_d = wb_last_idx_q;

        if (rd_op) begin
            // Resolution order is: zero for x0, then the same-edge write (bypass), then storage.
            if (reg_rs1 == '0)
                rs1_val_d = '0;
            else if (commit && (reg_rs1 == reg_w_reg_idx))
                rs1_val_d = reg_w_reg_val;
            else
                rs1_val_d = regs_q[reg_rs1];

            if (reg_rs2 == '0)
                rs2_val_d = '0;
            else if (commit && (reg_rs2 == reg_w_reg_idx))
                rs2_val_d = reg_w_reg_val;
            else
                rs2_val_d = regs_q[reg_rs2];
        end

        if (commit) begin
            wb_count_d    = wb_count_q + CNT_W'(1);
            wb_last_idx_d = reg_w_reg_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            rs1_val_q     <= '0;
            rs2_val_q     <= '0;
            rd_valid_q    <= 1'b0;
            wb_count_q    <= '0;
            wb_last_idx_q <= '0;
        end else begin
            if (commit) regs_q[reg_w_reg_idx] <= reg_w_reg_val;
            rs1_val_q     <= rs1_val_d;
            rs2_val_q     <= rs2_val_d;
            rd_valid_q    <= rd_valid_d;
            wb_count_q    <= wb_count_d;
            wb_last_idx_q <= wb_last_idx_d;
        end
    end

    assign reg_rs1_val = rs1_val_q;
    assign reg_rs2_val = rs2_val_q;
    assign rd_valid    = rd_valid_q;
    assign wb_count    = wb_count_q;
    assign wb_last_idx = wb_last_idx_q;

endmodule

// File: tb/tb_reg_file_wb.sv
module tb_reg_file_wb;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_w_op;
    logic [4:0]  reg_w_reg_idx;
    logic [31:0] reg_w_reg_val;
    logic        rd_op;
    logic [4:0]  reg_rs1, reg_rs2;
    logic [31:0] reg_rs1_val, reg_rs2_val;
    logic        rd_valid;
    logic [CW-1:0] wb_count;
    logic [4:0]  wb_last_idx;

    int total = 0;
    int bad   = 0;

    reg_file_wb #(.XLEN(32), .REG_IDX_W(5), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .reg_w_op(reg_w_op), .reg_w_reg_idx(reg_w_reg_idx), .reg_w_reg_val(reg_w_reg_val),
        .rd_op(rd_op), .reg_rs1(reg_rs1), .reg_rs2(reg_rs2),
        .reg_rs1_val(reg_rs1_val), .reg_rs2_val(reg_rs2_val), .rd_valid(rd_valid),
        .wb_count(wb_count), .wb_last_idx(wb_last_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: an array of register values plus the expected observable outputs.
    logic [31:0] m_regs [32];
    logic [31:0] e_rs1, e_rs2;
    logic        e_vld;
    int          e_cnt, e_last;
    bit          started = 0;

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
        if (reg_w_op && reg_w_reg_idx != 0 && reg_w_reg_idx == idx) return reg_w_reg_val;
        return m_regs[idx];
    endfunction

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            e_rs1 = 0; e_rs2 = 0; e_vld = 0; e_cnt = 0; e_last = 0;
        end else begin
            e_vld = rd_op;
            if (rd_op) begin
                e_rs1 = m_read(reg_rs1);
                e_rs2 = m_read(reg_rs2);
            end
            if (reg_w_op && reg_w_reg_idx != 0) begin
                m_regs[reg_w_reg_idx] = reg_w_reg_val;
                e_cnt  = (e_cnt + 1) % (1 << CW);
                e_last = reg_w_reg_idx;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cmp_rs1",   reg_rs1_val,       e_rs1);
            chk("cmp_rs2",   reg_rs2_val,       e_rs2);
            chk("cmp_vld",   {31'b0, rd_valid}, {31'b0, e_vld});
            chk("cmp_cnt",   32'(wb_count),     32'(e_cnt));
            chk("cmp_last",  32'(wb_last_idx),  32'(e_last));
        end
    end

    task automatic drive(input logic r, input logic w, input logic [4:0] wi, input logic [31:0] wv,
                         input logic rd, input logic [4:0] r1, input logic [4:0] r2);
        rst = r; reg_w_op = w; reg_w_reg_idx = wi; reg_w_reg_val = wv;
        rd_op = rd; reg_rs1 = r1; reg_rs2 = r2;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for two edges while a write and a read are also requested.
        rst = 1; reg_w_op = 1; reg_w_reg_idx = 5; reg_w_reg_val = 32'hDEADBEEF;
        rd_op = 1; reg_rs1 = 5; reg_rs2 = 5;
        drive(1, 1, 5, 32'hDEADBEEF, 1, 5, 5);
        chk("rst_vld", {31'b0, rd_valid}, 32'h0);
        drive(1, 1, 5, 32'hDEADBEEF, 1, 5, 5);
        chk("rst_cnt", 32'(wb_count), 32'h0);
        chk("rst_rs1", reg_rs1_val, 32'h0);
        drive(0, 0, 0, 0, 1, 5, 0);
        chk("rst_x5", reg_rs1_val, 32'h0);
        chk("rst_x5_vld", {31'b0, rd_valid}, 32'h1);

        // Basic write, then read one cycle later.
        drive(0, 1, 3, 32'h12345678, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 3, 0);
        chk("basic_rs1", reg_rs1_val, 32'h12345678);
        chk("basic_rs2", reg_rs2_val, 32'h0);
        chk("basic_vld", {31'b0, rd_valid}, 32'h1);
        chk("basic_cnt", 32'(wb_count), 32'h1);
        chk("basic_last", 32'(wb_last_idx), 32'h3);

        // x0 protection.
        drive(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("x0_rs1", reg_rs1_val, 32'h0);
        chk("x0_cnt", 32'(wb_count), 32'h1);
        chk("x0_last", 32'(wb_last_idx), 32'h3);

        // Bypass: old value 1, new value written on the same edge as the read.
        drive(0, 1, 7, 32'h00000001, 0, 0, 0);
        drive(0, 1, 7, 32'hA5A5A5A5, 1, 7, 7);
        chk("byp_rs1", reg_rs1_val, 32'hA5A5A5A5);
        chk("byp_rs2", reg_rs2_val, 32'hA5A5A5A5);
        chk("byp_cnt", 32'(wb_count), 32'h3);

        // Hold, with a filtered op=0 write to x9.
        drive(0, 1, 9, 32'h00000099, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 3, 7);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 9, 32'h55, 0, 9, 9);
            chk("hold_rs1", reg_rs1_val, 32'h12345678);
            chk("hold_rs2", reg_rs2_val, 32'hA5A5A5A5);
            chk("hold_vld", {31'b0, rd_valid}, 32'h0);
            chk("hold_cnt", 32'(wb_count), 32'h4);
        end
        drive(0, 0, 0, 0, 1, 9, 9);
        chk("x9_prior", reg_rs1_val, 32'h00000099);

        // Reset mid-read: the read completes, then a reset arrives together with a write.
        drive(0, 0, 0, 0, 1, 3, 9);
        chk("pre_rst_vld", {31'b0, rd_valid}, 32'h1);
        drive(1, 1, 3, 32'h77, 1, 3, 9);
        chk("midrst_vld", {31'b0, rd_valid}, 32'h0);
        chk("midrst_rs1", reg_rs1_val, 32'h0);
        chk("midrst_cnt", 32'(wb_count), 32'h0);
        drive(0, 0, 0, 0, 1, 3, 9);
        chk("uninit_x3", reg_rs1_val, 32'h0);
        chk("uninit_x9", reg_rs2_val, 32'h0);

        // Counter wrap: 17 writes with a 4-bit counter.
        for (int i = 1; i <= 17; i++) drive(0, 1, 5'(i), 32'h1000 + 32'(i), 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_cnt", 32'(wb_count), 32'h1);
        chk("wrap_last", 32'(wb_last_idx), 32'd17);
        for (int i = 1; i <= 17; i++) begin
            drive(0, 0, 0, 0, 1, 5'(i), 5'(18 - i));
            chk("wrap_rd1", reg_rs1_val, 32'h1000 + 32'(i));
            chk("wrap_rd2", reg_rs2_val, 32'h1000 + 32'(18 - i));
        end

        drive(0, 0, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
